// File: rtl/vga_timing_rx_if.sv
// Bundle between a raster source and the VGA timing receiver: pixel enable,
// received syncs, and the recovered timing and coordinates.
interface vga_timing_rx_if;
  logic       p_tick;
  logic       hs_in;
  logic       vs_in;
  logic       locked;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic [9:0] hs_width;
  logic [9:0] vs_width;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       frame_start;
  logic       lock_lost;

  modport master (
    output p_tick, hs_in, vs_in,
    input  locked, h_total, v_total, hs_width, vs_width,
           pixel_x, pixel_y, video_on, frame_start, lock_lost
  );

  modport slave (
    input  p_tick, hs_in, vs_in,
    output locked, h_total, v_total, hs_width, vs_width,
           pixel_x, pixel_y, video_on, frame_start, lock_lost
  );
endinterface

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures incoming hsync/vsync timing, locks onto a
// stable raster and regenerates pixel coordinates aligned to the received syncs.
module vga_timing_rx #(
  parameter int unsigned HD         = 640,
  parameter int unsigned VD         = 480,
  parameter int unsigned H_SYNC_POS = 656,
  parameter int unsigned V_SYNC_POS = 490,
  parameter int unsigned LOSS_LIMIT = 4
) (
  input  logic           clock_50,
  input  logic           reset_key,
  vga_timing_rx_if.slave bus
);

  localparam logic [9:0] C_HD   = 10'(HD);
  localparam logic [9:0] C_VD   = 10'(VD);
  localparam logic [9:0] C_HSP  = 10'(H_SYNC_POS);
  localparam logic [9:0] C_VSP  = 10'(V_SYNC_POS);
  localparam logic [3:0] C_LOSS = 4'(LOSS_LIMIT);

  typedef enum logic [1:0] {S_SEARCH, S_TRAIN, S_CHECK, S_LOCKED} state_t;
  state_t r_state, w_state_next;

  logic       r_hs_s1, r_hs_s2, r_hs_d, r_vs_s1, r_vs_s2, r_vs_d;
  logic [9:0] r_h_cnt, r_hs_lo_cnt, r_line_cnt, r_vs_lo_cnt;
  logic [9:0] r_h_total, r_v_total, r_hs_width, r_vs_width, r_pixel_x, r_pixel_y;
  logic [3:0] r_bad_cnt, w_bad_next, w_bad_inc;
  logic       r_frame_start, r_lock_lost, w_lost, w_latch_h, w_latch_v;
  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_timeout;
  logic       w_line_bad, w_frame_bad, w_locked, w_x_wrap, w_y_wrap;
  logic [9:0] w_period, w_frame_len;

  // Edge registers advance only on p_tick so an edge between ticks is taken on the next tick.
  assign w_hs_fall   = bus.p_tick & r_hs_d & ~r_hs_s2;
  assign w_hs_rise   = bus.p_tick & ~r_hs_d & r_hs_s2;
  assign w_vs_fall   = bus.p_tick & r_vs_d & ~r_vs_s2;
  assign w_vs_rise   = bus.p_tick & ~r_vs_d & r_vs_s2;
  assign w_timeout   = bus.p_tick & ~w_hs_fall & (r_h_cnt == '1);
  assign w_period    = r_h_cnt + 10'd1;
  assign w_frame_len = r_line_cnt + {9'd0, w_hs_fall};
  assign w_line_bad  = w_hs_fall & (w_period != r_h_total);
  assign w_frame_bad = w_vs_fall & (w_frame_len != r_v_total);
  assign w_bad_inc   = r_bad_cnt + 4'd1;
  assign w_locked    = (r_state == S_LOCKED);
  assign w_x_wrap    = w_locked ? (r_pixel_x == r_h_total - 10'd1) : (r_pixel_x == '1);
  assign w_y_wrap    = w_locked ? (r_pixel_y == r_v_total - 10'd1) : (r_pixel_y == '1);

  always_comb begin
    w_state_next = r_state;
    w_bad_next   = w_locked ? r_bad_cnt : '0;
    w_lost       = 1'b0;
    w_latch_h    = 1'b0;
    w_latch_v    = 1'b0;
    if (bus.p_tick) begin
      if (w_timeout) begin
        w_state_next = S_SEARCH;
        w_lost       = w_locked;
        w_bad_next   = '0;
      end else begin
        case (r_state)
          S_SEARCH: if (w_vs_fall) w_state_next = S_TRAIN;
          S_TRAIN: begin
            w_latch_h = w_hs_fall;
            if (w_vs_fall) begin
              w_latch_v    = 1'b1;
              w_state_next = S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_line_bad || w_frame_bad) w_state_next = S_SEARCH;
            else if (w_vs_fall)            w_state_next = S_LOCKED;
          end
          S_LOCKED: begin
            if (w_line_bad || w_frame_bad) begin
              if (w_bad_inc == C_LOSS) begin
                w_state_next = S_SEARCH;
                w_lost       = 1'b1;
                w_bad_next   = '0;
              end else begin
                w_bad_next = w_bad_inc;
              end
            end else if (w_hs_fall) begin
              w_bad_next = '0;
            end
          end
          default: w_state_next = S_SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_state <= S_SEARCH;
      {r_hs_s1, r_hs_s2, r_hs_d, r_vs_s1, r_vs_s2, r_vs_d} <= '0;
      {r_h_cnt, r_hs_lo_cnt, r_line_cnt, r_vs_lo_cnt} <= '0;
      {r_h_total, r_v_total, r_hs_width, r_vs_width} <= '0;
      {r_pixel_x, r_pixel_y} <= '0;
      r_bad_cnt     <= '0;
      r_frame_start <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_hs_s1       <= bus.hs_in;
      r_hs_s2       <= r_hs_s1;
      r_vs_s1       <= bus.vs_in;
      r_vs_s2       <= r_vs_s1;
      r_state       <= w_state_next;
      r_bad_cnt     <= w_bad_next;
      r_frame_start <= w_vs_fall;
      r_lock_lost   <= w_lost;
      if (bus.p_tick) begin
        r_hs_d <= r_hs_s2;
        r_vs_d <= r_vs_s2;

        if (w_hs_fall)            r_h_cnt <= '0;
        else if (r_h_cnt != '1)   r_h_cnt <= r_h_cnt + 10'd1;

        if (w_hs_fall)                             r_hs_lo_cnt <= 10'd1;
        else if (w_hs_rise)                        r_hs_width  <= r_hs_lo_cnt;
        else if (!r_hs_s2 && r_hs_lo_cnt != '1)    r_hs_lo_cnt <= r_hs_lo_cnt + 10'd1;

        if (w_vs_fall)      r_line_cnt <= '0;
        else if (w_hs_fall) r_line_cnt <= r_line_cnt + 10'd1;

        if (w_vs_fall)                  r_vs_lo_cnt <= {9'd0, w_hs_fall};
        else if (w_vs_rise)             r_vs_width  <= r_vs_lo_cnt;
        else if (!r_vs_s2 && w_hs_fall) r_vs_lo_cnt <= r_vs_lo_cnt + 10'd1;

        if (w_latch_h) r_h_total <= w_period;
        if (w_latch_v) r_v_total <= w_frame_len;

        if (w_hs_fall)     r_pixel_x <= C_HSP;
        else if (w_x_wrap) r_pixel_x <= '0;
        else               r_pixel_x <= r_pixel_x + 10'd1;

        if (w_vs_fall)                   r_pixel_y <= C_VSP;
        else if (w_x_wrap && !w_hs_fall) r_pixel_y <= w_y_wrap ? '0 : r_pixel_y + 10'd1;
      end
    end
  end

  assign bus.locked      = w_locked;
  assign bus.h_total     = r_h_total;
  assign bus.v_total     = r_v_total;
  assign bus.hs_width    = r_hs_width;
  assign bus.vs_width    = r_vs_width;
  assign bus.pixel_x     = r_pixel_x;
  assign bus.pixel_y     = r_pixel_y;
  assign bus.video_on    = w_locked && (r_pixel_x < C_HD) && (r_pixel_y < C_VD);
  assign bus.frame_start = r_frame_start;
  assign bus.lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: a reduced-size raster generator in loopback, with
// directed disturbances (stuck hsync, stretched lines, resets, short frame).
module tb_vga_timing_rx;
  localparam int HT = 40, HDV = 32, HSP = 34, HSW = 4;
  localparam int VT = 20, VDV = 15, VSP = 16, VSW = 2, LL = 4;
  localparam int FRAME_CLK = HT * VT * 2;

  logic clock_50 = 1'b0;
  logic reset_key = 1'b0;
  logic r_tick = 1'b0;
  logic force_hs = 1'b0;
  bit   track_en = 1'b0;

  int gx = 0, gy = 0, d1x = 0, d1y = 0, d2x = 0, d2y = 0;
  int stretch_req = 0, stretch_done = 0, short_req = 0, short_done = 0;
  int checks = 0, failures = 0;
  int fs_cnt = 0, lost_cnt = 0, rise_cnt = 0;
  logic prev_l = 1'b0;

  vga_timing_rx_if bus ();

  vga_timing_rx #(.HD(HDV), .VD(VDV), .H_SYNC_POS(HSP), .V_SYNC_POS(VSP), .LOSS_LIMIT(LL)) dut (
    .clock_50 (clock_50),
    .reset_key(reset_key),
    .bus      (bus)
  );

  always #10 clock_50 = ~clock_50;

  assign bus.p_tick = r_tick;
  assign bus.hs_in  = force_hs | !(gx >= HSP && gx < HSP + HSW);
  assign bus.vs_in  = !(gy >= VSP && gy < VSP + VSW);

  // Sync generator model plus a two-tick history of its coordinates: the receiver's
  // coordinates equal the generator's as they were two pixel ticks earlier.
  always @(posedge clock_50) begin
    r_tick <= ~r_tick;
    if (r_tick) begin
      d1x <= gx; d1y <= gy; d2x <= d1x; d2y <= d1y;
      if (gx == ((stretch_done < stretch_req) ? HT : HT - 1)) begin
        gx <= 0;
        if (stretch_done < stretch_req) stretch_done <= stretch_done + 1;
        if (gy == ((short_done < short_req) ? VT - 2 : VT - 1)) begin
          gy <= 0;
          if (short_done < short_req) short_done <= short_done + 1;
        end else begin
          gy <= gy + 1;
        end
      end else begin
        gx <= gx + 1;
      end
    end
  end

  always @(negedge clock_50) begin
    if (bus.frame_start) fs_cnt <= fs_cnt + 1;
    if (bus.lock_lost) lost_cnt <= lost_cnt + 1;
    if (bus.locked && !prev_l) rise_cnt <= rise_cnt + 1;
    prev_l <= bus.locked;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic wait_locked(input string name, input int bound);
    for (int i = 0; i < bound && !bus.locked; i++) @(negedge clock_50);
    chk(name, int'(bus.locked), 1);
    @(posedge clock_50);
  endtask

  task automatic wait_fs(input string name, input int target, input int bound);
    for (int i = 0; i < bound && fs_cnt < target; i++) @(posedge clock_50);
    chk(name, int'(fs_cnt >= target), 1);
  endtask

  task automatic wait_stretch(input string name);
    for (int i = 0; i < 2000 && stretch_done < stretch_req; i++) @(negedge clock_50);
    chk(name, int'(stretch_done >= stretch_req), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_video_on"}, int'(bus.video_on), 0);
    chk({tag, "_pixel_x"}, int'(bus.pixel_x), 0);
    chk({tag, "_pixel_y"}, int'(bus.pixel_y), 0);
    chk({tag, "_h_total"}, int'(bus.h_total), 0);
    chk({tag, "_v_total"}, int'(bus.v_total), 0);
    chk({tag, "_hs_width"}, int'(bus.hs_width), 0);
    chk({tag, "_vs_width"}, int'(bus.vs_width), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_lock_lost"}, int'(bus.lock_lost), 0);
  endtask

  initial begin
    int f0, l0, r0, vc;
    fork
      begin
        int   settle;
        logic c_prev;
        settle = 0;
        c_prev = 1'b0;
        forever begin
          @(negedge clock_50);
          if (reset_key) begin
            if (!bus.locked) chk("video_off_unlocked", int'(bus.video_on), 0);
            if (bus.lock_lost) chk("lost_with_lock_drop", int'({c_prev, bus.locked}), 2);
            settle = bus.locked ? settle + 1 : 0;
            if (track_en && bus.locked && settle > 100) begin
              chk("track_pixel_x", int'(bus.pixel_x), d2x);
              chk("track_pixel_y", int'(bus.pixel_y), d2y);
              chk("track_video_on", int'(bus.video_on), int'(d2x < HDV && d2y < VDV));
            end
          end else begin
            settle = 0;
          end
          c_prev = bus.locked;
        end
      end
    join_none

    ticks(5);
    chk_all_zero("reset");
    reset_key = 1'b1;

    // Loopback lock: SEARCH->TRAIN on 1st vsync, CHECK on 2nd, LOCKED on 3rd.
    wait_locked("initial_lock", 5 * FRAME_CLK);
    chk("lock_on_third_frame", fs_cnt, 3);
    chk("h_total", int'(bus.h_total), HT);
    chk("v_total", int'(bus.v_total), VT);
    chk("hs_width", int'(bus.hs_width), HSW);
    chk("vs_width", int'(bus.vs_width), VSW);

    track_en = 1'b1;
    f0 = fs_cnt;
    ticks(2 * FRAME_CLK);
    @(posedge clock_50);
    chk("frame_start_per_frame", fs_cnt - f0, 2);
    vc = 0;
    repeat (FRAME_CLK) begin
      @(negedge clock_50);
      if (r_tick && bus.video_on) vc++;
    end
    chk("video_on_per_frame", vc, HDV * VDV);
    chk("no_loss_in_loopback", lost_cnt, 0);
    track_en = 1'b0;

    // Stuck-high hsync forces a timeout.
    l0 = lost_cnt;
    force_hs = 1'b1;
    ticks(2 * 1100);
    @(posedge clock_50);
    chk("timeout_lock_lost_once", lost_cnt - l0, 1);
    chk("timeout_unlocked", int'(bus.locked), 0);
    force_hs = 1'b0;
    wait_locked("relock_after_timeout", 6 * FRAME_CLK);

    // LOSS_LIMIT-1 bad lines keep lock; LOSS_LIMIT consecutive drop it.
    ticks(200);
    l0 = lost_cnt;
    stretch_req = stretch_done + LL - 1;
    wait_stretch("stretch3_done");
    ticks(4 * HT);
    @(posedge clock_50);
    chk("stretch3_still_locked", int'(bus.locked), 1);
    chk("stretch3_no_loss", lost_cnt - l0, 0);
    ticks(8 * HT);
    chk("h_total_unchanged", int'(bus.h_total), HT);
    stretch_req = stretch_done + LL;
    wait_stretch("stretch4_done");
    ticks(4 * HT);
    @(posedge clock_50);
    chk("stretch4_lock_lost", lost_cnt - l0, 1);
    chk("stretch4_unlocked", int'(bus.locked), 0);

    // Mid-frame reset, then a full SEARCH/TRAIN/CHECK before relock.
    wait_locked("relock_after_stretch", 6 * FRAME_CLK);
    for (int i = 0; i < 2 * FRAME_CLK && gy != 5; i++) @(negedge clock_50);
    reset_key = 1'b0;
    #1;
    chk_all_zero("midframe_reset");
    ticks(3);
    reset_key = 1'b1;
    @(posedge clock_50);
    f0 = fs_cnt;
    l0 = lost_cnt;
    wait_locked("relock_after_reset", 5 * FRAME_CLK);
    chk("reset_relock_frames", fs_cnt - f0, 3);
    chk("reset_no_lock_lost", lost_cnt - l0, 0);

    // Short frame during CHECK: back to SEARCH silently.
    reset_key = 1'b0;
    ticks(2);
    reset_key = 1'b1;
    @(posedge clock_50);
    f0 = fs_cnt;
    r0 = rise_cnt;
    l0 = lost_cnt;
    wait_fs("short_reach_check", f0 + 2, 4 * FRAME_CLK);
    short_req = short_done + 1;
    wait_fs("short_reach_train", f0 + 4, 4 * FRAME_CLK);
    chk("short_never_locked", rise_cnt - r0, 0);
    chk("short_no_lock_lost", lost_cnt - l0, 0);
    chk("short_v_total_retrained", int'(bus.v_total), VT);
    wait_locked("relock_after_short", 4 * FRAME_CLK);
    chk("short_relock_frames", fs_cnt - f0, 6);

    track_en = 1'b1;
    ticks(FRAME_CLK + 300);
    track_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
